// File: rtl/cpu_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : cpu_ctrl_pkg
// Purpose  : Shared definitions for the multi-cycle CPU control path: FSM
//            state enum, opcode/funct constants, ALU opcode constants and
//            the alu_src_b / pc_source mux encodings. Imported by the
//            control FSM, the ALU and the datapath.
// Ports    : none (package)
// Revision : 1.0 - initial release
// ============================================================================
package cpu_ctrl_pkg;

  // Control FSM states
  typedef enum logic [3:0] {
    FETCH    = 4'd0,
    DECODE   = 4'd1,
    EXEC_R   = 4'd2,
    WB_R     = 4'd3,
    EXEC_I   = 4'd4,
    WB_I     = 4'd5,
    MEM_ADDR = 4'd6,
    MEM_RD   = 4'd7,
    WB_MEM   = 4'd8,
    MEM_WR   = 4'd9,
    BRANCH   = 4'd10,
    JUMP     = 4'd11
  } state_t;

  // How the ALU opcode is chosen in a given state
  typedef enum logic [1:0] {
    ALU_CLASS_ADD    = 2'd0,  // address / PC arithmetic
    ALU_CLASS_FUNCT  = 2'd1,  // R-type, decoded from funct
    ALU_CLASS_BRANCH = 2'd2   // equality test for beq/bne
  } alu_class_t;

  // Primary opcodes (instr[31:26])
  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_BNE   = 6'h05;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  // R-type function codes (instr[5:0])
  localparam logic [5:0] FUNCT_SLL = 6'h00;
  localparam logic [5:0] FUNCT_ADD = 6'h20;
  localparam logic [5:0] FUNCT_AND = 6'h24;
  localparam logic [5:0] FUNCT_OR  = 6'h25;
  localparam logic [5:0] FUNCT_SLT = 6'h2A;

  // ALU opcodes
  localparam logic [2:0] ALU_ADD  = 3'd0;
  localparam logic [2:0] ALU_NOOP = 3'd1;
  localparam logic [2:0] ALU_AND  = 3'd2;
  localparam logic [2:0] ALU_OR   = 3'd3;
  localparam logic [2:0] ALU_SLT  = 3'd4;
  localparam logic [2:0] ALU_SLL  = 3'd5;
  localparam logic [2:0] ALU_EQ   = 3'd6;  // result 0 when equal
  localparam logic [2:0] ALU_NE   = 3'd7;  // result 0 when not equal

  // alu_src_b mux encoding
  localparam logic [1:0] SRCB_REG      = 2'd0;
  localparam logic [1:0] SRCB_FOUR     = 2'd1;
  localparam logic [1:0] SRCB_IMM      = 2'd2;
  localparam logic [1:0] SRCB_IMM_SHL2 = 2'd3;

  // alu_src_a mux encoding
  localparam logic SRCA_PC  = 1'b0;
  localparam logic SRCA_REG = 1'b1;

  // pc_source mux encoding
  localparam logic [1:0] PCSRC_ALU    = 2'd0;
  localparam logic [1:0] PCSRC_ALUOUT = 2'd1;
  localparam logic [1:0] PCSRC_JUMP   = 2'd2;

  // True for the R-type function codes this core implements
  function automatic logic funct_is_legal(input logic [5:0] funct);
    return (funct == FUNCT_ADD) || (funct == FUNCT_AND) ||
           (funct == FUNCT_OR)  || (funct == FUNCT_SLT) ||
           (funct == FUNCT_SLL);
  endfunction

endpackage
`default_nettype wire

// File: rtl/alu_op_decode.sv
`default_nettype none
// ============================================================================
// Module   : alu_op_decode
// Purpose  : Combinational ALU opcode decoder. Maps the FSM's ALU class
//            plus the instruction opcode/funct to the 3-bit ALU opcode and
//            flags R-type function codes the core does not implement.
// Ports    : alu_class     in  2  ALU usage class of the current state
//            opcode        in  6  instr[31:26]
//            funct         in  6  instr[5:0]
//            alu_op        out 3  ALU opcode
//            illegal_funct out 1  funct is not a supported R-type function
// Revision : 1.0 - initial release
// ============================================================================
module alu_op_decode
  import cpu_ctrl_pkg::*;
(
  input  alu_class_t  alu_class,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  output logic [2:0]  alu_op,
  output logic        illegal_funct
);

  always_comb begin
    alu_op        = ALU_ADD;
    illegal_funct = ~funct_is_legal(funct);

    case (alu_class)
      ALU_CLASS_FUNCT: begin
        case (funct)
          FUNCT_ADD: alu_op = ALU_ADD;
          FUNCT_AND: alu_op = ALU_AND;
          FUNCT_OR:  alu_op = ALU_OR;
          FUNCT_SLT: alu_op = ALU_SLT;
          FUNCT_SLL: alu_op = ALU_SLL;
          // Unsupported functs are trapped in DECODE and never reach EXEC_R
          default:   alu_op = ALU_ADD;
        endcase
      end
      ALU_CLASS_BRANCH: begin
        alu_op = (opcode == OP_BNE) ? ALU_NE : ALU_EQ;
      end
      default: alu_op = ALU_ADD;
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : multicycle_control
// Purpose  : Multi-cycle control FSM for the single-issue 32-bit CPU. Walks
//            each instruction through fetch / decode / execute / memory /
//            writeback, drives the ALU opcode, datapath mux selects and
//            write enables, resolves branches from the ALU zero flag and
//            stalls on the memory-ready handshake.
// Ports    : clk         in  1  clock, rising edge
//            reset       in  1  asynchronous active-high reset
//            opcode      in  6  instr[31:26]
//            funct       in  6  instr[5:0]
//            zero        in  1  ALU zero flag
//            mem_ready   in  1  memory completed current access
//            alu_op      out 3  ALU opcode
//            alu_src_a   out 1  0 PC, 1 register A
//            alu_src_b   out 2  0 reg B, 1 const 4, 2 imm, 3 imm<<2
//            i_or_d      out 1  memory address: 0 PC, 1 ALUOut
//            mem_read    out 1  memory read strobe
//            mem_write   out 1  memory write strobe
//            ir_write    out 1  instruction register load
//            pc_en       out 1  PC load enable
//            pc_source   out 2  0 ALU, 1 ALUOut, 2 jump target
//            reg_write   out 1  register file write enable
//            reg_dst     out 1  0 rt, 1 rd
//            mem_to_reg  out 1  writeback data from memory
//            illegal     out 1  unsupported instruction pulse
// Revision : 1.0 - initial release
// ============================================================================
module multicycle_control
  import cpu_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic [5:0]  opcode,
  input  logic [5:0]  funct,
  input  logic        zero,
  input  logic        mem_ready,
  output logic [2:0]  alu_op,
  output logic        alu_src_a,
  output logic [1:0]  alu_src_b,
  output logic        i_or_d,
  output logic        mem_read,
  output logic        mem_write,
  output logic        ir_write,
  output logic        pc_en,
  output logic [1:0]  pc_source,
  output logic        reg_write,
  output logic        reg_dst,
  output logic        mem_to_reg,
  output logic        illegal
);

  state_t     state;
  state_t     next_state;
  alu_class_t alu_class;
  logic       illegal_funct;

  // Enables as decoded from the state, before reset gating
  logic mem_read_fsm;
  logic mem_write_fsm;
  logic ir_write_fsm;
  logic pc_en_fsm;
  logic reg_write_fsm;
  logic illegal_fsm;

  alu_op_decode u_alu_op_decode (
    .alu_class     (alu_class),
    .opcode        (opcode),
    .funct         (funct),
    .alu_op        (alu_op),
    .illegal_funct (illegal_funct)
  );

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= FETCH;
    end else begin
      state <= next_state;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state and output decode
  // --------------------------------------------------------------------------
  always_comb begin
    next_state    = state;
    alu_class     = ALU_CLASS_ADD;
    alu_src_a     = SRCA_PC;
    alu_src_b     = SRCB_REG;
    i_or_d        = 1'b0;
    pc_source     = PCSRC_ALU;
    reg_dst       = 1'b0;
    mem_to_reg    = 1'b0;
    mem_read_fsm  = 1'b0;
    mem_write_fsm = 1'b0;
    ir_write_fsm  = 1'b0;
    pc_en_fsm     = 1'b0;
    reg_write_fsm = 1'b0;
    illegal_fsm   = 1'b0;

    case (state)
      FETCH: begin
        // PC + 4 is computed every cycle of the fetch; the IR and PC only
        // latch in the cycle the memory completes, so a stall never loads
        // twice.
        mem_read_fsm = 1'b1;
        alu_src_b    = SRCB_FOUR;
        if (mem_ready) begin
          ir_write_fsm = 1'b1;
          pc_en_fsm    = 1'b1;
          next_state   = DECODE;
        end
      end

      DECODE: begin
        // Branch target precomputed into ALUOut while decoding
        alu_src_b = SRCB_IMM_SHL2;
        case (opcode)
          OP_RTYPE: begin
            if (illegal_funct) begin
              illegal_fsm = 1'b1;
              next_state  = FETCH;
            end else begin
              next_state  = EXEC_R;
            end
          end
          OP_LW, OP_SW:   next_state = MEM_ADDR;
          OP_BEQ, OP_BNE: next_state = BRANCH;
          OP_ADDI:        next_state = EXEC_I;
          OP_J:           next_state = JUMP;
          default: begin
            illegal_fsm = 1'b1;
            next_state  = FETCH;
          end
        endcase
      end

      EXEC_R: begin
        alu_class  = ALU_CLASS_FUNCT;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        next_state = WB_R;
      end

      WB_R: begin
        reg_write_fsm = 1'b1;
        reg_dst       = 1'b1;
        next_state    = FETCH;
      end

      EXEC_I: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        next_state = WB_I;
      end

      WB_I: begin
        reg_write_fsm = 1'b1;
        next_state    = FETCH;
      end

      MEM_ADDR: begin
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_IMM;
        // Only lw and sw reach this state
        next_state = (opcode == OP_LW) ? MEM_RD : MEM_WR;
      end

      MEM_RD: begin
        mem_read_fsm = 1'b1;
        i_or_d       = 1'b1;
        if (mem_ready) begin
          next_state = WB_MEM;
        end
      end

      WB_MEM: begin
        reg_write_fsm = 1'b1;
        mem_to_reg    = 1'b1;
        next_state    = FETCH;
      end

      MEM_WR: begin
        mem_write_fsm = 1'b1;
        i_or_d        = 1'b1;
        if (mem_ready) begin
          next_state = FETCH;
        end
      end

      BRANCH: begin
        alu_class  = ALU_CLASS_BRANCH;
        alu_src_a  = SRCA_REG;
        alu_src_b  = SRCB_REG;
        pc_source  = PCSRC_ALUOUT;
        // The ALU test is arranged so zero=1 means "take the branch"
        pc_en_fsm  = zero;
        next_state = FETCH;
      end

      JUMP: begin
        pc_source  = PCSRC_JUMP;
        pc_en_fsm  = 1'b1;
        next_state = FETCH;
      end

      default: next_state = FETCH;
    endcase
  end

  // The state register already sits in FETCH during reset, whose read
  // strobe would otherwise be visible; hold every enable low while reset
  // is applied.
  assign mem_read  = mem_read_fsm  & ~reset;
  assign mem_write = mem_write_fsm & ~reset;
  assign ir_write  = ir_write_fsm  & ~reset;
  assign pc_en     = pc_en_fsm     & ~reset;
  assign reg_write = reg_write_fsm & ~reset;
  assign illegal   = illegal_fsm   & ~reset;

endmodule
`default_nettype wire

// File: tb/tb_multicycle_control.sv
`default_nettype none
// ============================================================================
// Module   : tb_multicycle_control
// Purpose  : Self-checking bench for multicycle_control. Instruction
//            sequences are expanded into per-cycle expected outputs from the
//            instruction-level behaviour; a monitor compares every cycle.
// Revision : 1.0 - initial release
// ============================================================================
module tb_multicycle_control;

  logic       clk = 1'b0;
  logic       reset;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       zero;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       i_or_d;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_en;
  logic [1:0] pc_source;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       illegal;

  always #5 clk = ~clk;

  multicycle_control dut (
    .clk        (clk),
    .reset      (reset),
    .opcode     (opcode),
    .funct      (funct),
    .zero       (zero),
    .mem_ready  (mem_ready),
    .alu_op     (alu_op),
    .alu_src_a  (alu_src_a),
    .alu_src_b  (alu_src_b),
    .i_or_d     (i_or_d),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .ir_write   (ir_write),
    .pc_en      (pc_en),
    .pc_source  (pc_source),
    .reg_write  (reg_write),
    .reg_dst    (reg_dst),
    .mem_to_reg (mem_to_reg),
    .illegal    (illegal)
  );

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_en;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       illegal;
  } outs_t;

  typedef struct {
    outs_t      exp;
    logic       mr;
    logic       zr;
    logic       rst;
    logic       rst_mid;  // raise reset asynchronously after this cycle is sampled
    logic [5:0] op;
    logic [5:0] fn;
  } cyc_t;

  typedef struct {
    outs_t exp;
    logic  async_chk;
  } sb_t;

  outs_t act;
  assign act = {alu_op, alu_src_a, alu_src_b, i_or_d, mem_read, mem_write,
                ir_write, pc_en, pc_source, reg_write, reg_dst, mem_to_reg,
                illegal};

  cyc_t       plan[$];
  sb_t        sb[$];
  int         vectors = 0;
  int         miscompares = 0;
  logic       stim_done = 1'b0;
  logic [5:0] cur_op;
  logic [5:0] cur_fn;

  // ---------------- reference model ----------------
  function automatic outs_t reset_vec();
    outs_t e = '0;
    e.alu_src_b = 2'd1;  // FETCH select; only enables are forced low
    return e;
  endfunction

  function automatic logic [2:0] r_alu(input logic [5:0] fn);
    case (fn)
      6'h20:   return 3'd0;
      6'h24:   return 3'd2;
      6'h25:   return 3'd3;
      6'h2A:   return 3'd4;
      default: return 3'd5;  // 0x00 sll
    endcase
  endfunction

  function automatic bit funct_ok(input logic [5:0] fn);
    return fn == 6'h20 || fn == 6'h24 || fn == 6'h25 || fn == 6'h2A || fn == 6'h00;
  endfunction

  function automatic bit op_ok(input logic [5:0] op);
    return op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
           op == 6'h05 || op == 6'h08 || op == 6'h02;
  endfunction

  task automatic add_cyc(input outs_t e, input logic mr, input logic zr,
                         input logic rst, input logic rmid);
    cyc_t c;
    c.exp = e; c.mr = mr; c.zr = zr; c.rst = rst; c.rst_mid = rmid;
    c.op = cur_op; c.fn = cur_fn;
    plan.push_back(c);
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // One instruction: fetch with fst wait cycles, mst wait cycles on data
  // memory, branch zero flag zb, rmid = reset during the address phase.
  task automatic instr(input logic [5:0] op, input logic [5:0] fn, input logic zb,
                       input int fst, input int mst, input bit rmid);
    outs_t e;
    cur_op = op; cur_fn = fn;
    // fetch
    e = '0; e.mem_read = 1'b1; e.alu_src_b = 2'd1;
    for (int i = 0; i < fst; i++) add_cyc(e, 1'b0, rb(), 1'b0, 1'b0);
    e.ir_write = 1'b1; e.pc_en = 1'b1;
    add_cyc(e, 1'b1, rb(), 1'b0, 1'b0);
    // decode
    e = '0; e.alu_src_b = 2'd3;
    e.illegal = !op_ok(op) || (op == 6'h00 && !funct_ok(fn));
    add_cyc(e, rb(), rb(), 1'b0, 1'b0);
    if (e.illegal) return;
    case (op)
      6'h00: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_op = r_alu(fn);
        add_cyc(e, rb(), rb(), 1'b0, 1'b0);
        e = '0; e.reg_write = 1'b1; e.reg_dst = 1'b1;
        add_cyc(e, rb(), rb(), 1'b0, 1'b0);
      end
      6'h08: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
        add_cyc(e, rb(), rb(), 1'b0, 1'b0);
        e = '0; e.reg_write = 1'b1;
        add_cyc(e, rb(), rb(), 1'b0, 1'b0);
      end
      6'h23, 6'h2B: begin
        e = '0; e.alu_src_a = 1'b1; e.alu_src_b = 2'd2;
        add_cyc(e, rb(), rb(), 1'b0, logic'(rmid));
        if (rmid) begin
          add_cyc(reset_vec(), 1'b1, rb(), 1'b1, 1'b0);
          add_cyc(reset_vec(), rb(), rb(), 1'b1, 1'b0);
          return;
        end
        e = '0; e.i_or_d = 1'b1;
        if (op == 6'h23) e.mem_read = 1'b1; else e.mem_write = 1'b1;
        for (int i = 0; i <= mst; i++) add_cyc(e, logic'(i == mst), rb(), 1'b0, 1'b0);
        if (op == 6'h23) begin
          e = '0; e.reg_write = 1'b1; e.mem_to_reg = 1'b1;
          add_cyc(e, rb(), rb(), 1'b0, 1'b0);
        end
      end
      6'h04, 6'h05: begin
        e = '0; e.alu_src_a = 1'b1; e.pc_source = 2'd1;
        e.alu_op = (op == 6'h04) ? 3'd6 : 3'd7;
        e.pc_en = zb;
        add_cyc(e, rb(), zb, 1'b0, 1'b0);
      end
      default: begin  // j
        e = '0; e.pc_source = 2'd2; e.pc_en = 1'b1;
        add_cyc(e, rb(), rb(), 1'b0, 1'b0);
      end
    endcase
  endtask

  // ---------------- stimulus ----------------
  initial begin
    logic [5:0] ops [8];
    logic [5:0] op;
    logic [5:0] fn;
    reset = 1'b1; opcode = '0; funct = '0; zero = 1'b0; mem_ready = 1'b0;
    ops[0] = 6'h00; ops[1] = 6'h23; ops[2] = 6'h2B; ops[3] = 6'h04;
    ops[4] = 6'h05; ops[5] = 6'h08; ops[6] = 6'h02; ops[7] = 6'h3F;
    cur_op = '0; cur_fn = '0;

    for (int i = 0; i < 3; i++) add_cyc(reset_vec(), 1'b1, 1'b0, 1'b1, 1'b0);
    // directed
    instr(6'h00, 6'h20, 1'b0, 0, 0, 0);   // add, 4 cycles
    instr(6'h23, 6'h11, 1'b0, 0, 2, 0);   // lw with 2 wait cycles, 7 total
    instr(6'h04, 6'h00, 1'b1, 0, 0, 0);   // beq taken
    instr(6'h04, 6'h00, 1'b0, 0, 0, 0);   // beq not taken
    instr(6'h05, 6'h00, 1'b1, 0, 0, 0);   // bne
    instr(6'h3F, 6'h20, 1'b0, 0, 0, 0);   // illegal opcode
    instr(6'h00, 6'h22, 1'b0, 0, 0, 0);   // illegal funct
    instr(6'h2B, 6'h00, 1'b0, 0, 0, 1);   // sw, reset in MEM_ADDR
    instr(6'h00, 6'h25, 1'b0, 3, 0, 0);   // 3-cycle fetch stall
    instr(6'h08, 6'h00, 1'b0, 0, 0, 0);   // addi
    instr(6'h02, 6'h00, 1'b0, 1, 0, 0);   // j
    instr(6'h2B, 6'h00, 1'b0, 0, 1, 0);   // sw with a wait cycle
    // random
    for (int n = 0; n < 120; n++) begin
      op = ops[$urandom_range(0, 7)];
      fn = 6'($urandom_range(0, 63));
      if (op == 6'h3F) op = 6'($urandom_range(0, 63));
      if (op == 6'h00 && $urandom_range(0, 3) != 0) begin
        case ($urandom_range(0, 4))
          0: fn = 6'h20;
          1: fn = 6'h24;
          2: fn = 6'h25;
          3: fn = 6'h2A;
          default: fn = 6'h00;
        endcase
      end
      instr(op, fn, rb(), int'($urandom_range(0, 3)), int'($urandom_range(0, 3)),
            $urandom_range(0, 15) == 0);
    end

    @(posedge clk); #1;
    while (plan.size() > 0) begin
      cyc_t c;
      sb_t  s;
      c = plan.pop_front();
      reset = c.rst; mem_ready = c.mr; zero = c.zr; opcode = c.op; funct = c.fn;
      s.exp = c.exp; s.async_chk = c.rst_mid;
      sb.push_back(s);
      vectors++;
      if (c.rst_mid) begin
        @(negedge clk); #2;
        reset = 1'b1;
      end
      @(posedge clk); #1;
    end
    stim_done = 1'b1;
  end

  // ---------------- monitor / scoreboard ----------------
  initial begin
    int idle;
    sb_t s;
    idle = 0;
    forever begin
      @(negedge clk);
      if (sb.size() > 0) begin
        idle = 0;
        s = sb.pop_front();
        if (act !== s.exp) begin
          miscompares++;
          $display("FAIL cycle_outputs t=%0t op=%h fn=%h: got %h expected %h",
                   $time, opcode, funct, act, s.exp);
        end
        if (s.async_chk) begin
          #3;  // reset has just been raised mid-cycle
          if (act !== reset_vec()) begin
            miscompares++;
            $display("FAIL async_reset t=%0t: got %h expected %h",
                     $time, act, reset_vec());
          end
        end
      end else if (stim_done) begin
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
      end else begin
        idle++;
        if (idle > 50) begin
          miscompares++;
          $display("FAIL stimulus_timeout: got idle %0d expected <= 50", idle);
          $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
          $finish;
        end
      end
    end
  end

endmodule
`default_nettype wire
